// File: rtl/ricevitore_rdy_ack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ricevitore_rdy_ack_pkg
// Purpose : Shared defaults and a pointer-width helper for the two-phase
//           RDY/ACK receiver.
// Contents: DEF_N, DEF_DEPTH, DEF_CW default parameter values;
//           ptr_w() returns log2(depth), minimum 1, used to size head/tail.
// Revision: 1.0 - initial release
// ============================================================================
package ricevitore_rdy_ack_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CW    = 2;

  // Smallest w with 2^w >= depth. For a power-of-2 depth this is exactly
  // log2(depth), so a w-bit pointer wraps modulo depth with no extra logic.
  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ricevitore_rdy_ack_ind.sv
`default_nettype none
// ============================================================================
// Module  : ind_transizione
// Purpose : 1-bit transition indicator. Each cycle with enable high flips the
//           output level; reset returns it to 0.
// Ports   : clock  - system clock
//           reset  - asynchronous active-high reset
//           enable - flip the level on this rising edge
//           level  - current indicator level
// Revision: 1.0 - initial release
// ============================================================================
module ind_transizione (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic level
);

  logic r_level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_level <= 1'b0;
    end else if (enable) begin
      r_level <= ~r_level;
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/ricevitore_rdy_ack.sv
`default_nettype none
// ============================================================================
// Module  : ricevitore_rdy_ack
// Purpose : Receiving end of a two-phase RDY/ACK channel. Each level change
//           on rdy_in carries one word; the word is stored in a circular
//           buffer and ack_out flips to release the sender. Buffered words
//           are offered to the consumer through a valid/take interface.
// Ports   : clock, reset     - clock, asynchronous active-high reset
//           in_data, rdy_in  - sender word and RDY transition indicator
//           ack_out          - ACK transition indicator back to the sender
//           out_data         - oldest buffered word (0 when empty)
//           out_valid        - buffer not empty
//           out_take         - consumer pops the head word this cycle
//           count            - occupied slots, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module ricevitore_rdy_ack
  import ricevitore_rdy_ack_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  in_data,
  input  logic          rdy_in,
  output logic          ack_out,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_take,
  output logic [CW-1:0] count
);

  localparam int          PW     = ptr_w(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [PW-1:0] C_PONE = PW'(1);

  logic [N-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_rdy_seen;

  logic w_pending;
  logic w_pop;
  logic w_accept;

  // A message is pending while the sender's level differs from the last
  // level we consumed; an even number of toggles therefore looks like none.
  assign w_pending = rdy_in ^ r_rdy_seen;
  assign w_pop     = out_take & (r_count != '0);
  // Full buffer still accepts if the head is popped on the same edge.
  assign w_accept  = w_pending & ((r_count != C_FULL) | out_take);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdy_seen <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_rdy_seen <= rdy_in;
        r_tail     <= r_tail + C_PONE;
      end
      if (w_pop) begin
        r_head <= r_head + C_PONE;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: out_data is gated by count, so stale words are
  // never observable.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_tail] <= in_data;
    end
  end

  ind_transizione u_ack (
    .clock  (clock),
    .reset  (reset),
    .enable (w_accept),
    .level  (ack_out)
  );

  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign out_data  = (r_count != '0) ? r_mem[r_head] : '0;

endmodule
`default_nettype wire

// File: doc/ricevitore_rdy_ack.md
Name: ricevitore_rdy_ack

Overview:
- Receiving end of the two-phase (level-transition) RDY/ACK channel used between units in the datapath.
- Sender places a word on in_data and toggles rdy_in. The block stores the word in a small circular buffer and toggles ack_out to free the sender.
- Buffered words are offered to the consuming unit through a valid/take interface.
- Sits at the input side of any unit fed by a remote sender; pairs with the sender-side interface on the same clock.

Parameters:
- N, 32, data word width in bits.
- DEPTH, 2, number of buffer slots; power of 2, minimum 2.
- CW, 2, width of count; must satisfy 2^CW > DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N  message word from the sender; valid whenever rdy_in differs from the internal seen level.
- rdy_in  input  1  sender's RDY transition indicator; each level change means one new message.
- ack_out  output  1  ACK transition indicator to the sender; toggles once per accepted message.
- out_data  output  N  oldest buffered word; 0 when the buffer is empty.
- out_valid  output  1  1 when count != 0.
- out_take  input  1  consumer pops the head word this cycle; ignored when out_valid=0.
- count  output  CW  number of occupied buffer slots, 0..DEPTH.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) clears everything immediately:
  - rdy_seen=0, ack_out=0, head=0, tail=0, count=0, out_valid=0, out_data=0.
  - Buffered words are discarded. The sender shares the same reset, so both indicators restart at 0.
- Pending message: rdy_in != rdy_seen. Both signals are synchronous to clock; no synchroniser is used.
- Accept condition at a rising edge: pending AND (count<DEPTH OR (count==DEPTH AND out_take)).
  - A full buffer with a simultaneous pop accepts in the same cycle.
- On accept:
  - mem[tail] <= in_data; tail <= tail+1, wrapping modulo DEPTH.
  - rdy_seen <= rdy_in; ack_out <= ~ack_out.
  - Latency: ack_out changes 1 clock after the rdy_in toggle when space is available.
- Pending while full with no take: message held, no ack toggle. in_data must stay stable; that is the sender's obligation, since it is waiting for ACK.
- Pop (out_take AND out_valid): head <= head+1, wrapping modulo DEPTH.
- count update on each edge:
  - accept only: +1
  - pop only: -1
  - both: unchanged
- Read path: out_data = mem[head] combinationally when count!=0, else 0. The word written on an accept becomes visible at the head on the next cycle if the buffer was empty. There is no fall-through in the accept cycle.
- Protocol violation: sender toggles rdy_in twice without waiting for ack.
  - The receiver sees only the level difference.
  - Two toggles before an accept are indistinguishable from none, so no message is taken.
  - There is no error flag; the sender is responsible.
- Implicit control states, derived from count and the pending condition:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- Transitions follow the count rule above. Wrap-around of head/tail needs no special case because DEPTH is a power of 2.

Decomposition:
- Shared include file: default N, default DEPTH, and a log2-style macro used to size the head/tail pointers.
- One natural sub-module: ind_transizione.
  - 1-bit transition-indicator register with enable: toggles its output on enable, clears on reset.
  - Instantiated for ack_out.
  - rdy_seen is a plain enabled 1-bit register inside the top module.
- Buffer array and pointers stay in the top module.

Test Plan (N=8, DEPTH=2):
- Reset assert mid-run with 2 words buffered -> count=0, out_valid=0, out_data=0, ack_out=0 immediately, before the next clock edge.
- Single message: in_data=8'hA5, rdy_in 0->1 -> ack_out 0->1 one cycle later; next cycle out_valid=1, out_data=8'hA5; out_take=1 for one cycle -> count=0.
- Fill without take: send 8'h11, 8'h22, each after its ack -> count=2. Send 8'h33 -> no ack toggle while full, ack_out remains at its level. Pulse out_take -> 8'h33 accepted that same edge, count stays 2; then pops yield 8'h22, 8'h33 in order.
- Wrap-around: push/pop 5 words 8'h01..8'h05 alternately -> output order exactly 01..05, count never exceeds 1, ack_out toggles 5 times.
- Simultaneous accept and pop at count=1 -> count stays 1, head advances, out_data shows the next word on the following cycle.
- out_take asserted while empty -> no change to count or pointers; a later message is still delivered correctly.
